pc_fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch over a req/ack handshake to instruction memory.

---
 rtl/pc_fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer: drives a single-outstanding
// req/ack fetch port and redirects on taken branches or jumps, flushing in-flight work.
//
// state | meaning
// BOOT  | one cycle after reset release, redirects ignored
// IDLE  | no request outstanding; waits for stall to drop
// REQ   | request outstanding at pc, data will be delivered
// DRAIN | request outstanding but flushed; data discarded, then pc=pend_tgt
module pc_fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic              Branch_deci,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              flush,
  output logic              misalign_err
);

  typedef enum logic [1:0] {BOOT, IDLE, REQ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;

  logic              redir;
  logic [ADDR_W-1:0] tgt_raw;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_misal;

  // Jump wins over a simultaneous taken branch.
  assign redir     = jump_valid | (branch_valid & Branch_deci);
  assign tgt_raw   = jump_valid ? jump_target : branch_target;
  assign tgt       = {tgt_raw[ADDR_W-1:2], 2'b00};
  assign tgt_misal = |tgt_raw[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_tgt_d    = pend_tgt_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = 1'b0;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    case (state_q)
      BOOT: state_d = IDLE;
      IDLE: begin
        if (redir) begin
          pc_d       = tgt;
          flush_d    = 1'b1;
          misalign_d = tgt_misal;
        end else if (!stall) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redir) begin
          flush_d    = 1'b1;
          misalign_d = tgt_misal;
          if (imem_ack) begin
            pc_d    = tgt;
            state_d = stall ? IDLE : REQ;
          end else begin
            pend_tgt_d = tgt;
            state_d    = DRAIN;
          end
        end else if (imem_ack) begin
          fetch_valid_d = 1'b1;
          fetch_pc_d    = pc_q;
          pc_d          = pc_q + ADDR_W'(4);
          state_d       = stall ? IDLE : REQ;
        end
      end
      DRAIN: begin
        if (redir) begin
          pend_tgt_d = tgt;
          flush_d    = 1'b1;
          misalign_d = tgt_misal;
        end
        if (imem_ack) begin
          pc_d    = redir ? tgt : pend_tgt_q;
          state_d = stall ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_tgt_q    <= '0;
      fetch_pc_q    <= '0;
      req_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_tgt_q    <= pend_tgt_d;
      fetch_pc_q    <= fetch_pc_d;
      req_q         <= req_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign fetch_pc     = fetch_pc_q;
  assign flush        = flush_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vector table, hand-written
// wrap/reset sequences, then randomized traffic against a transaction-level model.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic        Branch_deci = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_valid(branch_valid), .Branch_deci(Branch_deci), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .flush(flush), .misalign_err(misalign_err)
  );

  // Reference model: tracks "is a request outstanding" and "will its data be kept".
  logic        m_boot, m_out, m_disc;
  logic [31:0] m_pc, m_redir_to;
  logic        m_fv, m_flush, m_mis;
  logic [31:0] m_fpc;

  task automatic model_reset();
    m_boot = 1'b1; m_out = 1'b0; m_disc = 1'b0;
    m_pc = 32'h0; m_redir_to = 32'h0;
    m_fv = 1'b0; m_flush = 1'b0; m_mis = 1'b0; m_fpc = 32'h0;
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] t;
    redir = jump_valid || (branch_valid && Branch_deci);
    t     = jump_valid ? jump_target : branch_target;
    m_fv = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (redir) begin
        m_flush = 1'b1;
        m_mis   = (t % 4) != 0;
      end
      if (!m_out) begin
        if (redir) m_pc = t - (t % 4);
        else if (!stall) m_out = 1'b1;
      end else begin
        if (redir) begin
          m_redir_to = t - (t % 4);
          m_disc     = 1'b1;
        end
        if (imem_ack) begin
          if (m_disc) m_pc = m_redir_to;
          else begin
            m_fv  = 1'b1;
            m_fpc = m_pc;
            m_pc  = m_pc + 32'd4;
          end
          m_disc = 1'b0;
          m_out  = !stall;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_req",   32'(imem_req),     32'(m_out));
    check("model_addr",  imem_addr,         m_pc);
    check("model_fv",    32'(fetch_valid),  32'(m_fv));
    check("model_flush", 32'(flush),        32'(m_flush));
    check("model_mis",   32'(misalign_err), 32'(m_mis));
    if (m_fv) check("model_fpc", fetch_pc, m_fpc);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(input logic s, input logic bv, input logic bd, input logic [31:0] bt,
                        input logic jv, input logic [31:0] jt, input logic ack);
    stall = s; branch_valid = bv; Branch_deci = bd; branch_target = bt;
    jump_valid = jv; jump_target = jt; imem_ack = ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s, bv, bd;
    logic [31:0] bt;
    logic        jv;
    logic [31:0] jt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] fpc;
    logic        fl, mis;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // stall bv bd btgt jv jtgt ack | req addr fv fpc flush mis
    tbl[0]  = '{0,0,0,32'h0,  0,32'h0,  1, 0,32'h0,  0,32'h0,  0,0};
    tbl[1]  = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h0,  0,32'h0,  0,0};
    tbl[2]  = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h4,  1,32'h0,  0,0};
    tbl[3]  = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h8,  1,32'h4,  0,0};
    tbl[4]  = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'hC,  1,32'h8,  0,0};
    tbl[5]  = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h10, 1,32'hC,  0,0};
    tbl[6]  = '{0,1,1,32'h40, 0,32'h0,  0, 1,32'h10, 0,32'h0,  1,0};
    tbl[7]  = '{0,0,0,32'h0,  0,32'h0,  0, 1,32'h10, 0,32'h0,  0,0};
    tbl[8]  = '{0,0,0,32'h0,  0,32'h0,  0, 1,32'h10, 0,32'h0,  0,0};
    tbl[9]  = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h40, 0,32'h0,  0,0};
    tbl[10] = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h44, 1,32'h40, 0,0};
    tbl[11] = '{0,1,0,32'h80, 0,32'h0,  1, 1,32'h48, 1,32'h44, 0,0};
    tbl[12] = '{0,0,1,32'h200,0,32'h0,  1, 1,32'h4C, 1,32'h48, 0,0};
    tbl[13] = '{0,1,1,32'h200,1,32'h100,1, 1,32'h100,0,32'h0,  1,0};
    tbl[14] = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h104,1,32'h100,0,0};
    tbl[15] = '{1,0,0,32'h0,  0,32'h0,  1, 0,32'h108,1,32'h104,0,0};
    tbl[16] = '{1,0,0,32'h0,  0,32'h0,  0, 0,32'h108,0,32'h0,  0,0};
    tbl[17] = '{1,0,0,32'h0,  1,32'h7,  0, 0,32'h4,  0,32'h0,  1,1};
    tbl[18] = '{0,0,0,32'h0,  0,32'h0,  0, 1,32'h4,  0,32'h0,  0,0};
    tbl[19] = '{0,0,0,32'h0,  0,32'h0,  1, 1,32'h8,  1,32'h4,  0,0};

    set_in(0,0,0,0,0,0,1);
    do_reset();
    check("reset_req",   32'(imem_req),     32'h0);
    check("reset_addr",  imem_addr,         32'h0);
    check("reset_fpc",   fetch_pc,          32'h0);
    check("reset_flush", 32'(flush),        32'h0);

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].s, tbl[i].bv, tbl[i].bd, tbl[i].bt, tbl[i].jv, tbl[i].jt, tbl[i].ack);
      step();
      check($sformatf("vec%0d_req", i),   32'(imem_req),     32'(tbl[i].req));
      check($sformatf("vec%0d_addr", i),  imem_addr,         tbl[i].addr);
      check($sformatf("vec%0d_fv", i),    32'(fetch_valid),  32'(tbl[i].fv));
      check($sformatf("vec%0d_flush", i), 32'(flush),        32'(tbl[i].fl));
      check($sformatf("vec%0d_mis", i),   32'(misalign_err), 32'(tbl[i].mis));
      if (tbl[i].fv) check($sformatf("vec%0d_fpc", i), fetch_pc, tbl[i].fpc);
    end

    // PC wrap at the top of the address space.
    set_in(0,0,0,0,1,32'hFFFF_FFFC,1);
    step();
    check("wrap_jump_addr", imem_addr, 32'hFFFF_FFFC);
    set_in(0,0,0,0,0,0,1);
    step();
    check("wrap_fpc",  fetch_pc,  32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset while a request is outstanding.
    set_in(0,0,0,0,0,0,0);
    step();
    check("pre_rst_req", 32'(imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midreq_rst_req",  32'(imem_req),    32'h0);
    check("midreq_rst_addr", imem_addr,        32'h0);
    check("midreq_rst_fv",   32'(fetch_valid), 32'h0);
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1'($urandom),
             $urandom, $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
